alu_op_sequencer: RTL and testbench

//  Upstream controller for the 8-bit ALU. Accepts one operation per valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Single-issue IDLE/EXEC/WB controller feeding an external
//            combinational 8-bit ALU from a small register file.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op_code,
    input  logic [AW-1:0] op_rd,
    input  logic [AW-1:0] op_rs,
    input  logic          op_use_imm,
    input  logic [7:0]    op_imm,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [7:0]    alu_ctl,
    input  logic [7:0]    alu_out,
    input  logic          alu_cf,
    input  logic          alu_sf,
    input  logic          alu_zf,
    output logic          cf,
    output logic          sf,
    output logic          zf,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_SUB = 4'h1;
    localparam logic [3:0] c_OP_ADC = 4'h2;
    localparam logic [3:0] c_OP_AND = 4'h3;
    localparam logic [3:0] c_OP_OR  = 4'h4;
    localparam logic [3:0] c_OP_XOR = 4'h5;
    localparam logic [3:0] c_OP_NOT = 4'h6;
    localparam logic [3:0] c_OP_NEG = 4'h7;
    localparam logic [3:0] c_OP_INC = 4'h8;
    localparam logic [3:0] c_OP_DEC = 4'h9;
    localparam logic [3:0] c_OP_SHL = 4'hA;
    localparam logic [3:0] c_OP_SHR = 4'hB;
    localparam logic [3:0] c_OP_SAR = 4'hC;
    localparam logic [3:0] c_OP_MOV = 4'hD;
    localparam logic [3:0] c_OP_CMP = 4'hE;

    // Control-word bit positions: {ci,nb,ic,na,xo,no,sr,ss}
    localparam logic [7:0] c_CI = 8'h80;
    localparam logic [7:0] c_NB = 8'h40;
    localparam logic [7:0] c_IC = 8'h20;
    localparam logic [7:0] c_NA = 8'h10;
    localparam logic [7:0] c_XO = 8'h08;
    localparam logic [7:0] c_NO = 8'h04;
    localparam logic [7:0] c_SR = 8'h02;
    localparam logic [7:0] c_SS = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_regs [NREGS];
    logic [AW-1:0]   r_rd;
    logic            r_wb_en;
    logic            r_illegal;
    logic [7:0]      r_res;
    logic            r_res_cf;
    logic            r_res_sf;
    logic            r_res_zf;
    logic            r_ready;
    logic [7:0]      r_alu_a;
    logic [7:0]      r_alu_b;
    logic [7:0]      r_alu_ctl;
    logic            r_cf;
    logic            r_sf;
    logic            r_zf;
    logic            r_done;
    logic            r_err;

    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [7:0]      w_ctl;
    logic            w_illegal;

    always_comb begin
        w_a       = r_regs[op_rd];
        w_b       = op_use_imm ? op_imm : r_regs[op_rs];
        w_ctl     = 8'h00;
        w_illegal = 1'b0;
        case (op_code)
            c_OP_ADD: w_ctl = 8'h00;
            c_OP_SUB: w_ctl = c_CI | c_NB;
            c_OP_ADC: w_ctl = r_cf ? c_CI : 8'h00;
            c_OP_AND: w_ctl = c_IC | c_NA | c_NB | c_NO | c_XO;
            c_OP_OR:  w_ctl = c_IC | c_XO;
            c_OP_XOR: w_ctl = c_IC;
            c_OP_NOT: begin w_ctl = c_NB | c_IC; w_b = 8'h00; end
            c_OP_NEG: begin w_ctl = c_CI | c_NA; w_b = 8'h00; end
            c_OP_INC: begin w_ctl = c_CI;        w_b = 8'h00; end
            c_OP_DEC: begin w_ctl = c_NB;        w_b = 8'h00; end
            c_OP_SHL: w_b = w_a;
            c_OP_SHR: begin w_ctl = c_SR;        w_b = 8'h00; end
            c_OP_SAR: begin w_ctl = c_SR | c_SS; w_b = 8'h00; end
            c_OP_MOV: w_a = 8'h00;
            c_OP_CMP: w_ctl = c_CI | c_NB;
            default: begin
                w_a       = 8'h00;
                w_b       = 8'h00;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_rd      <= '0;
            r_wb_en   <= 1'b0;
            r_illegal <= 1'b0;
            r_res     <= 8'h00;
            r_res_cf  <= 1'b0;
            r_res_sf  <= 1'b0;
            r_res_zf  <= 1'b0;
            r_ready   <= 1'b1;
            r_alu_a   <= 8'h00;
            r_alu_b   <= 8'h00;
            r_alu_ctl <= 8'h00;
            r_cf      <= 1'b0;
            r_sf      <= 1'b0;
            r_zf      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_rd      <= op_rd;
                        r_illegal <= w_illegal;
                        r_wb_en   <= !w_illegal && (op_code != c_OP_CMP);
                        r_alu_a   <= w_a;
                        r_alu_b   <= w_b;
                        r_alu_ctl <= w_ctl;
                        r_ready   <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_res     <= alu_out;
                    r_res_cf  <= alu_cf;
                    r_res_sf  <= alu_sf;
                    r_res_zf  <= alu_zf;
                    // ALU inputs must read zero everywhere outside EXEC
                    r_alu_a   <= 8'h00;
                    r_alu_b   <= 8'h00;
                    r_alu_ctl <= 8'h00;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    if (r_wb_en) begin
                        r_regs[r_rd] <= r_res;
                    end
                    if (!r_illegal) begin
                        r_cf <= r_res_cf;
                        r_sf <= r_res_sf;
                        r_zf <= r_res_zf;
                    end
                    r_done  <= 1'b1;
                    r_err   <= r_illegal;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign op_ready = r_ready;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ctl  = r_alu_ctl;
    assign cf       = r_cf;
    assign sf       = r_sf;
    assign zf       = r_zf;
    assign done     = r_done;
    assign err      = r_err;
    assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed bench for alu_op_sequencer with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [1:0] op_rd;
    logic [1:0] op_rs;
    logic       op_use_imm;
    logic [7:0] op_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_ctl;
    logic [7:0] alu_out;
    logic       alu_cf;
    logic       alu_sf;
    logic       alu_zf;
    logic       cf;
    logic       sf;
    logic       zf;
    logic       done;
    logic       err;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.NREGS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_rd      (op_rd),
        .op_rs      (op_rs),
        .op_use_imm (op_use_imm),
        .op_imm     (op_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_out    (alu_out),
        .alu_cf     (alu_cf),
        .alu_sf     (alu_sf),
        .alu_zf     (alu_zf),
        .cf         (cf),
        .sf         (sf),
        .zf         (zf),
        .done       (done),
        .err        (err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural ALU: optional operand inversion, adder or xor/or, shifter, output inversion
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_s;
    logic [7:0] m_o;
    logic [8:0] m_sum;
    logic       m_c;
    always_comb begin
        m_a   = alu_ctl[4] ? ~alu_a : alu_a;
        m_b   = alu_ctl[6] ? ~alu_b : alu_b;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {8'h00, alu_ctl[7]};
        m_s   = m_sum[7:0];
        m_c   = m_sum[8];
        if (alu_ctl[5]) begin
            m_c = 1'b0;
            m_s = alu_ctl[3] ? (m_a | m_b) : (m_a ^ m_b);
        end
        if (alu_ctl[1]) begin
            m_c = m_s[0];
            m_s = {alu_ctl[0] & m_s[7], m_s[7:1]};
        end
        m_o     = alu_ctl[2] ? ~m_s : m_s;
        alu_out = m_o;
        alu_cf  = m_c;
        alu_sf  = m_o[7];
        alu_zf  = (m_o == 8'h00);
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_is(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    task automatic flags_are(input string tag, input logic ecf, input logic esf, input logic ezf);
        chk({tag, " flags"}, {29'h0, cf, sf, zf}, {29'h0, ecf, esf, ezf});
    endtask

    // One op with a single-cycle valid; checks ready/done timing around it
    task automatic issue(input string tag, input logic [3:0] code, input logic [1:0] rd,
                         input logic [1:0] rs, input logic ui, input logic [7:0] imm);
        int n;
        @(negedge clk);
        op_code = code; op_rd = rd; op_rs = rs; op_use_imm = ui; op_imm = imm;
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready_idle"}, {31'h0, op_ready}, 32'h1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk({tag, " ready_exec"}, {31'h0, op_ready}, 32'h0);
        @(negedge clk);
        chk({tag, " ready_wb"}, {31'h0, op_ready}, 32'h0);
        chk({tag, " done_early"}, {31'h0, done}, 32'h0);
        @(negedge clk);
        chk({tag, " done"}, {31'h0, done}, 32'h1);
        chk({tag, " err"}, {31'h0, err}, {31'h0, (code == 4'hF)});
        chk({tag, " ctl_idle"}, {8'h0, alu_a, alu_b, alu_ctl}, 32'h0);
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'h0, done}, 32'h0);
    endtask

    logic [3:0] hold_code [3];
    int         d0;
    int         acc_t [3];
    int         cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_code = 4'h0; op_rd = 2'd0; op_rs = 2'd0;
        op_use_imm = 1'b0; op_imm = 8'h00; dbg_addr = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst ready", {31'h0, op_ready}, 32'h1);
        chk("rst done_err", {30'h0, done, err}, 32'h0);
        chk("rst alu", {8'h0, alu_a, alu_b, alu_ctl}, 32'h0);
        flags_are("rst", 1'b0, 1'b0, 1'b0);
        reg_is("rst R3", 2'd3, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic moves and add
        issue("mov r0", 4'hD, 2'd0, 2'd0, 1'b1, 8'd9);
        issue("mov r1", 4'hD, 2'd1, 2'd0, 1'b1, 8'd8);
        issue("add r0r1", 4'h0, 2'd0, 2'd1, 1'b0, 8'd0);
        reg_is("add R0", 2'd0, 8'd17);
        flags_are("add", 1'b0, 1'b0, 1'b0);

        // Carry wrap, then ADC consumes the carry
        issue("mov r2", 4'hD, 2'd2, 2'd0, 1'b1, 8'd0);
        issue("mov r0b", 4'hD, 2'd0, 2'd0, 1'b1, 8'd254);
        issue("add wrap", 4'h0, 2'd0, 2'd0, 1'b1, 8'd2);
        reg_is("wrap R0", 2'd0, 8'd0);
        flags_are("wrap", 1'b1, 1'b0, 1'b1);
        issue("adc r2", 4'h2, 2'd2, 2'd0, 1'b1, 8'd0);
        reg_is("adc R2", 2'd2, 8'd1);
        flags_are("adc", 1'b0, 1'b0, 1'b0);

        // SUB and CMP
        issue("mov r3", 4'hD, 2'd3, 2'd0, 1'b1, 8'd10);
        issue("sub r3", 4'h1, 2'd3, 2'd0, 1'b1, 8'd4);
        reg_is("sub R3", 2'd3, 8'd6);
        flags_are("sub", 1'b1, 1'b0, 1'b0);
        issue("cmp r3", 4'hE, 2'd3, 2'd0, 1'b1, 8'd6);
        reg_is("cmp R3", 2'd3, 8'd6);
        flags_are("cmp", 1'b1, 1'b0, 1'b1);

        // Shifts and logic
        issue("mov r1 fc", 4'hD, 2'd1, 2'd0, 1'b1, 8'hFC);
        issue("sar r1", 4'hC, 2'd1, 2'd0, 1'b0, 8'h00);
        reg_is("sar R1", 2'd1, 8'hFE);
        flags_are("sar", 1'b0, 1'b1, 1'b0);
        issue("shr r1", 4'hB, 2'd1, 2'd0, 1'b0, 8'h00);
        reg_is("shr R1", 2'd1, 8'h7F);
        flags_are("shr", 1'b0, 1'b0, 1'b0);
        issue("mov r1 4", 4'hD, 2'd1, 2'd0, 1'b1, 8'd4);
        issue("shl r1", 4'hA, 2'd1, 2'd0, 1'b0, 8'h00);
        reg_is("shl R1", 2'd1, 8'd8);
        issue("mov r2 10", 4'hD, 2'd2, 2'd0, 1'b1, 8'd10);
        issue("and r2", 4'h3, 2'd2, 2'd0, 1'b1, 8'd9);
        reg_is("and R2", 2'd2, 8'd8);
        issue("mov r3 10", 4'hD, 2'd3, 2'd0, 1'b1, 8'd10);
        issue("or r3", 4'h4, 2'd3, 2'd0, 1'b1, 8'd9);
        reg_is("or R3", 2'd3, 8'd11);

        // rd==rs, NEG/NOT/DEC/XOR chain on R0
        issue("mov r0 3", 4'hD, 2'd0, 2'd0, 1'b1, 8'd3);
        issue("add r0r0", 4'h0, 2'd0, 2'd0, 1'b0, 8'h00);
        reg_is("rdrs R0", 2'd0, 8'd6);
        issue("neg r0", 4'h7, 2'd0, 2'd0, 1'b0, 8'h00);
        reg_is("neg R0", 2'd0, 8'hFA);
        issue("not r0", 4'h6, 2'd0, 2'd0, 1'b0, 8'h00);
        reg_is("not R0", 2'd0, 8'h05);
        issue("dec r0", 4'h9, 2'd0, 2'd0, 1'b0, 8'h00);
        reg_is("dec R0", 2'd0, 8'h04);
        flags_are("dec", 1'b1, 1'b0, 1'b0);
        issue("xor r0", 4'h5, 2'd0, 2'd0, 1'b1, 8'hFF);
        reg_is("xor R0", 2'd0, 8'hFB);
        flags_are("xor", 1'b0, 1'b1, 1'b0);

        // Held op_valid: INC, INC, illegal; accepts must be 3 cycles apart
        hold_code[0] = 4'h8; hold_code[1] = 4'h8; hold_code[2] = 4'hF;
        d0 = done_cnt;
        @(negedge clk);
        op_rd = 2'd0; op_rs = 2'd0; op_use_imm = 1'b0; op_imm = 8'h00;
        op_code = hold_code[0];
        op_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold ready_idle %0d", k), {31'h0, op_ready}, 32'h1);
            @(posedge clk);
            acc_t[k] = cyc;
            #1;
            if (k < 2) op_code = hold_code[k+1];
            else       op_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("hold ready_exec %0d", k), {31'h0, op_ready}, 32'h0);
            @(negedge clk);
            chk($sformatf("hold ready_wb %0d", k), {31'h0, op_ready}, 32'h0);
            @(negedge clk);
            chk($sformatf("hold done %0d", k), {31'h0, done}, 32'h1);
            chk($sformatf("hold err %0d", k), {31'h0, err}, {31'h0, (k == 2)});
        end
        chk("hold spacing 01", acc_t[1] - acc_t[0], 32'd3);
        chk("hold spacing 12", acc_t[2] - acc_t[1], 32'd3);
        repeat (3) @(negedge clk);
        chk("hold done count", done_cnt - d0, 32'd3);
        reg_is("hold R0", 2'd0, 8'hFD);
        flags_are("illegal", 1'b0, 1'b1, 1'b0);

        // Reset during EXEC drops the op
        @(negedge clk);
        op_code = 4'h0; op_rd = 2'd0; op_use_imm = 1'b1; op_imm = 8'd5; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("midrst in_exec", {31'h0, op_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", {31'h0, op_ready}, 32'h1);
        chk("midrst alu", {8'h0, alu_a, alu_b, alu_ctl}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst no done", done_cnt - d0, 32'd0);
        reg_is("midrst R0", 2'd0, 8'h00);
        flags_are("midrst", 1'b0, 1'b0, 1'b0);
        chk("midrst ready after", {31'h0, op_ready}, 32'h1);

        // Block still works after the reset
        issue("post mov", 4'hD, 2'd1, 2'd0, 1'b1, 8'h5A);
        reg_is("post R1", 2'd1, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
